// File: rtl/sa_ctrl_pkg.sv
// Shared types and sizing helpers for the systolic-array feed controller.
package sa_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } sa_state_e;

    function automatic int unsigned beats_f(input int unsigned k, input int unsigned out);
        return k / out;
    endfunction

    function automatic int unsigned t_width_f(input int unsigned beats, input int unsigned rows);
        return (beats + rows > 1) ? $clog2(beats + rows) : 1;
    endfunction

    function automatic int unsigned cnt_width_f(input int unsigned k);
        return (k > 0) ? $clog2(k + 1) : 1;
    endfunction

endpackage

// File: rtl/sa_row_fill_cnt.sv
// Per-row saturating fill counter; reports full now and full after this cycle's beat.
module sa_row_fill_cnt
    import sa_ctrl_pkg::*;
#(
    parameter int unsigned K = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic full_c,
    output logic full_nxt_c
);

    localparam int unsigned CNT_W = cnt_width_f(K);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && !full_c) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign full_c     = (cnt_q == CNT_W'(K));
    assign full_nxt_c = full_c | (inc & (cnt_q == CNT_W'(K - 1)));

endmodule

// File: rtl/sa_feed_ctrl.sv
// Sequences load, skewed read-out and drain of the sp_buf row bank feeding the systolic array.
module sa_feed_ctrl
    import sa_ctrl_pkg::*;
#(
    parameter int unsigned ROWS  = 2,
    parameter int unsigned K     = 4,
    parameter int unsigned OUT   = 2,
    parameter int unsigned DRAIN = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     ld_valid,
    input  logic [$clog2(ROWS)-1:0]  ld_row,
    output logic                     ld_ready,
    output logic [ROWS-1:0]          buf_en_in,
    output logic [ROWS-1:0]          buf_en_out,
    output logic                     busy,
    output logic                     done,
    output logic                     ld_err
);

    localparam int unsigned ROW_W   = $clog2(ROWS);
    localparam int unsigned BEATS   = beats_f(K, OUT);
    localparam int unsigned T_W     = t_width_f(BEATS, ROWS);
    localparam int unsigned T_LAST  = BEATS + ROWS - 2;
    localparam int unsigned DR_W    = (DRAIN > 1) ? $clog2(DRAIN) : 1;
    localparam int unsigned DR_LAST = (DRAIN > 0) ? DRAIN - 1 : 0;

    sa_state_e        state_q, state_d;
    logic [T_W-1:0]   t_q, t_d;
    logic [DR_W-1:0]  drain_q, drain_d;
    logic             err_q, err_d;
    logic             row_clr_c;
    logic             load_c;
    logic             beat_bad_c;
    logic [ROWS-1:0]  row_hit_c;
    logic [ROWS-1:0]  row_full_c;
    logic [ROWS-1:0]  row_full_nxt_c;

    // One-hot row decode; an out-of-range ld_row simply matches nothing.
    always_comb begin
        row_hit_c = '0;
        for (int unsigned r = 0; r < ROWS; r++) begin
            row_hit_c[r] = (ld_row == ROW_W'(r));
        end
    end

    assign load_c     = ld_valid & ld_ready & ~abort;
    assign buf_en_in  = {ROWS{load_c}} & row_hit_c & ~row_full_c;
    assign beat_bad_c = load_c & ~|(row_hit_c & ~row_full_c);

    for (genvar r = 0; r < int'(ROWS); r++) begin : g_row
        sa_row_fill_cnt #(.K(K)) u_fill (
            .clk        (clk),
            .rst_n      (rst_n),
            .clr        (row_clr_c),
            .inc        (buf_en_in[r]),
            .full_c     (row_full_c[r]),
            .full_nxt_c (row_full_nxt_c[r])
        );
    end

    always_comb begin
        state_d   = state_q;
        t_d       = t_q;
        drain_d   = drain_q;
        err_d     = err_q;
        row_clr_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d   = ST_LOAD;
                    t_d       = '0;
                    drain_d   = '0;
                    err_d     = 1'b0;
                    row_clr_c = 1'b1;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    if (beat_bad_c) begin
                        err_d = 1'b1;
                    end
                    if (&row_full_nxt_c) begin
                        state_d = ST_STREAM;
                        t_d     = '0;
                    end
                end
            end
            ST_STREAM: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (t_q == T_W'(T_LAST)) begin
                    drain_d = '0;
                    state_d = (DRAIN == 0) ? ST_DONE : ST_DRAIN;
                end else begin
                    t_d = t_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (drain_q == DR_W'(DR_LAST)) begin
                    state_d = ST_DONE;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            t_q      <= '0;
            drain_q  <= '0;
            err_q    <= 1'b0;
            ld_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            t_q      <= t_d;
            drain_q  <= drain_d;
            err_q    <= err_d;
            ld_ready <= (state_d == ST_LOAD);
            busy     <= (state_d inside {ST_LOAD, ST_STREAM, ST_DRAIN});
            done     <= (state_d == ST_DONE);
        end
    end

    assign ld_err = err_q;

    // Diagonal skew: row r reads during t in [r, r+BEATS).
    always_comb begin
        buf_en_out = '0;
        if (state_q == ST_STREAM) begin
            for (int unsigned r = 0; r < ROWS; r++) begin
                buf_en_out[r] = (32'(t_q) >= r) && ((32'(t_q) - r) < BEATS);
            end
        end
    end

endmodule

// File: tb/tb_sa_feed_ctrl.sv
// Randomized and directed bench for sa_feed_ctrl against a cycle-level behavioural model.
module tb_sa_feed_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic st[2];
    logic ab[2];
    logic lv[2];
    int   lr[2];

    logic [0:0] lr0;
    logic [1:0] lr1;
    assign lr0 = 1'(lr[0]);
    assign lr1 = 2'(lr[1]);

    logic       rdy0, busy0, done0, err0;
    logic [1:0] ei0, eo0;
    logic       rdy1, busy1, done1, err1;
    logic [3:0] ei1, eo1;

    sa_feed_ctrl #(.ROWS(2), .K(4), .OUT(2), .DRAIN(3)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .abort(ab[0]), .ld_valid(lv[0]),
        .ld_row(lr0), .ld_ready(rdy0), .buf_en_in(ei0), .buf_en_out(eo0),
        .busy(busy0), .done(done0), .ld_err(err0)
    );

    sa_feed_ctrl #(.ROWS(4), .K(2), .OUT(1), .DRAIN(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .abort(ab[1]), .ld_valid(lv[1]),
        .ld_row(lr1), .ld_ready(rdy1), .buf_en_in(ei1), .buf_en_out(eo1),
        .busy(busy1), .done(done1), .ld_err(err1)
    );

    logic [31:0] g_ei[2], g_eo[2], g_rdy[2], g_busy[2], g_done[2], g_err[2];
    assign g_ei[0]   = 32'(ei0);
    assign g_eo[0]   = 32'(eo0);
    assign g_rdy[0]  = 32'(rdy0);
    assign g_busy[0] = 32'(busy0);
    assign g_done[0] = 32'(done0);
    assign g_err[0]  = 32'(err0);
    assign g_ei[1]   = 32'(ei1);
    assign g_eo[1]   = 32'(eo1);
    assign g_rdy[1]  = 32'(rdy1);
    assign g_busy[1] = 32'(busy1);
    assign g_done[1] = 32'(done1);
    assign g_err[1]  = 32'(err1);

    function automatic int p_rows(input int i);  return (i == 0) ? 2 : 4; endfunction
    function automatic int p_k(input int i);     return (i == 0) ? 4 : 2; endfunction
    function automatic int p_beats(input int i); return (i == 0) ? 2 : 2; endfunction
    function automatic int p_drain(input int i); return (i == 0) ? 3 : 0; endfunction

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input int i, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s inst%0d @%0t: got %0h expected %0h", nm, i, $time, got, exp);
        end
    endtask

    // Model: idle / loading (per-row fill counts) / running (cycles since load completed).
    int m_mode[2];
    int m_cnt[2][4];
    int m_run[2];
    bit m_err[2];

    task automatic model_step(input int i);
        int rows, k, beats, drain, span, s;
        bit all_full;
        logic [31:0] e_ei, e_eo, e_rdy, e_busy, e_done, e_err;
        rows = p_rows(i); k = p_k(i); beats = p_beats(i); drain = p_drain(i);
        span = beats + rows - 1;
        if (!rst_n) begin
            m_mode[i] = 0;
            m_err[i]  = 1'b0;
            for (int r = 0; r < 4; r++) m_cnt[i][r] = 0;
        end
        e_ei = 0; e_eo = 0; e_rdy = 0; e_busy = 0; e_done = 0;
        e_err = 32'(m_err[i]);
        s = m_run[i] - 1;
        if (m_mode[i] == 1) begin
            e_rdy = 1; e_busy = 1;
            if (lv[i] && !ab[i] && lr[i] < rows)
                if (m_cnt[i][lr[i]] < k) e_ei = 32'd1 << lr[i];
        end else if (m_mode[i] == 2) begin
            if (s < span)
                for (int r = 0; r < rows; r++)
                    if (s >= r && s - r < beats) e_eo = e_eo | (32'd1 << r);
            e_busy = 32'(s < span + drain);
            e_done = 32'(s == span + drain);
        end
        chk("en_in", i, g_ei[i], e_ei);
        chk("en_out", i, g_eo[i], e_eo);
        chk("ld_ready", i, g_rdy[i], e_rdy);
        chk("busy", i, g_busy[i], e_busy);
        chk("done", i, g_done[i], e_done);
        chk("ld_err", i, g_err[i], e_err);
        if (!rst_n) return;
        case (m_mode[i])
            0: if (st[i] && !ab[i]) begin
                m_mode[i] = 1;
                m_err[i]  = 1'b0;
                for (int r = 0; r < 4; r++) m_cnt[i][r] = 0;
            end
            1: if (ab[i]) m_mode[i] = 0;
               else begin
                   if (lv[i]) begin
                       if (e_ei != 0) m_cnt[i][lr[i]]++;
                       else m_err[i] = 1'b1;
                   end
                   all_full = 1'b1;
                   for (int r = 0; r < rows; r++) if (m_cnt[i][r] != k) all_full = 1'b0;
                   if (all_full) begin m_mode[i] = 2; m_run[i] = 1; end
               end
            default: if (ab[i] || s == span + drain) m_mode[i] = 0;
                     else m_run[i]++;
        endcase
    endtask

    initial begin
        m_mode = '{0, 0};
        m_run  = '{0, 0};
        forever begin
            @(negedge clk);
            model_step(0);
            model_step(1);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int i);
        st[i] = 1'b1;
        cyc();
        st[i] = 1'b0;
    endtask

    task automatic fill(input int i, input bit pin, input bit junk);
        for (int b = 0; b < p_rows(i) * p_k(i); b++) begin
            lv[i] = 1'b1;
            lr[i] = b % p_rows(i);
            st[i] = junk && (b == 2);
            #1;
            if (pin) chk("load_onehot", i, g_ei[i], 32'd1 << (b % p_rows(i)));
            cyc();
        end
        lv[i] = 1'b0;
        st[i] = 1'b0;
    endtask

    task automatic pin_stream(input int i, input bit junk);
        logic [31:0] exp_eo[7];
        int n;
        if (i == 0) begin exp_eo = '{1, 3, 2, 0, 0, 0, 0}; n = 7; end
        else        begin exp_eo = '{1, 3, 6, 12, 8, 0, 0}; n = 6; end
        for (int j = 1; j <= n; j++) begin
            if (junk) begin
                lv[i] = 1'b1;
                lr[i] = $urandom_range(0, p_rows(i) - 1);
            end
            @(negedge clk);
            chk("pin_en_out", i, g_eo[i], exp_eo[j-1]);
            chk("pin_done", i, g_done[i], 32'(j == n));
            chk("pin_busy", i, g_busy[i], 32'(j != n));
            @(posedge clk);
            #1;
        end
        lv[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i);
        int n = 0;
        while (m_mode[i] != 0 && n < 400) begin
            cyc();
            n++;
        end
        n_chk++;
        if (m_mode[i] != 0) begin
            n_err++;
            $display("FAIL idle_timeout inst%0d: still busy after %0d cycles, required idle", i, n);
        end
    endtask

    task automatic rand_op(input int i);
        do_start(i);
        for (int c = 0; c < 400 && m_mode[i] != 0; c++) begin
            lv[i] = ($urandom_range(0, 3) != 0);
            lr[i] = $urandom_range(0, p_rows(i) - 1);
            ab[i] = ($urandom_range(0, 59) == 0);
            st[i] = ($urandom_range(0, 7) == 0);
            cyc();
        end
        lv[i] = 1'b0; ab[i] = 1'b0; st[i] = 1'b0;
        wait_idle(i);
        cyc();
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            st[i] = 1'b0; ab[i] = 1'b0; lv[i] = 1'b0; lr[i] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_busy", i, g_busy[i], 0);
            chk("rst_en_out", i, g_eo[i], 0);
            chk("rst_ld_ready", i, g_rdy[i], 0);
            chk("rst_ld_err", i, g_err[i], 0);
        end
        rst_n = 1'b1;
        cyc();

        // Basic operation with literal stream timing.
        do_start(0);
        fill(0, 1'b1, 1'b0);
        pin_stream(0, 1'b0);
        cyc();

        // Overfill a row: no enable, sticky error, stays loading.
        do_start(0);
        for (int b = 0; b < 7; b++) begin
            lv[0] = 1'b1; lr[0] = b % 2;
            cyc();
        end
        lv[0] = 1'b1; lr[0] = 0;
        #1;
        chk("full_row_en_in", 0, g_ei[0], 0);
        cyc();
        lv[0] = 1'b0;
        chk("ld_err_set", 0, g_err[0], 1);
        chk("still_loading", 0, g_rdy[0], 1);
        lv[0] = 1'b1; lr[0] = 1;
        cyc();
        lv[0] = 1'b0;
        @(negedge clk);
        chk("stream_after_fill", 0, g_eo[0], 1);
        chk("ld_err_kept", 0, g_err[0], 1);
        wait_idle(0);
        do_start(0);
        chk("ld_err_cleared", 0, g_err[0], 0);
        fill(0, 1'b0, 1'b0);
        wait_idle(0);
        cyc();

        // Abort at STREAM t=1.
        do_start(0);
        fill(0, 1'b0, 1'b0);
        cyc();
        ab[0] = 1'b1;
        cyc();
        ab[0] = 1'b0;
        chk("abort_en_out", 0, g_eo[0], 0);
        chk("abort_busy", 0, g_busy[0], 0);
        chk("abort_done", 0, g_done[0], 0);
        repeat (6) cyc();

        // Asynchronous reset during DRAIN.
        do_start(0);
        fill(0, 1'b0, 1'b0);
        repeat (3) cyc();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 0, g_busy[0], 0);
        chk("arst_en_out", 0, g_eo[0], 0);
        chk("arst_done", 0, g_done[0], 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc();
        do_start(0);
        fill(0, 1'b1, 1'b0);
        pin_stream(0, 1'b0);
        cyc();

        // Stray start in LOAD and stray ld_valid in STREAM change nothing.
        do_start(0);
        fill(0, 1'b1, 1'b1);
        pin_stream(0, 1'b1);
        cyc();

        // Wider bank, no drain.
        do_start(1);
        fill(1, 1'b1, 1'b0);
        pin_stream(1, 1'b0);
        cyc();

        for (int n = 0; n < 40; n++) rand_op(n % 2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/sa_feed_ctrl.md
Name: sa_feed_ctrl

Overview:
- Sequencer for a bank of ROWS scratchpad row buffers (sp_buf instances) feeding the systolic matrix-multiply array.
- Gates buffer writes during a load phase, then issues skewed (diagonal) read enables so row r starts r cycles after row 0.
- Waits a fixed drain interval for the array pipeline to empty, then signals completion.
- Sits between the host/DMA load interface and the sp_buf bank.

Parameters:
- ROWS, 2, number of row buffers / array rows driven.
- K, 4, elements loaded per row per operation; equals sp_buf DEPTH.
- OUT, 2, elements popped per sp_buf read beat; K % OUT == 0 required.
- DRAIN, 3, cycles after last read beat before done (array fill/flush latency).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  begin an operation; sampled only in IDLE.
- abort  in  1  synchronous cancel; returns to IDLE next cycle, no done.
- ld_valid  in  1  load beat present on the shared buffer data bus.
- ld_row  in  $clog2(ROWS)  target row of the load beat.
- ld_ready  out  1  controller accepts load beats (high only in LOAD).
- buf_en_in  out  ROWS  per-row sp_buf en_in.
- buf_en_out  out  ROWS  per-row sp_buf en_out.
- busy  out  1  high in LOAD, STREAM, DRAIN.
- done  out  1  one-cycle pulse on operation completion.
- ld_err  out  1  sticky flag: a beat targeted a full row or ld_row >= ROWS; cleared on start.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; all counters 0.
  - buf_en_in, buf_en_out, busy, done, ld_ready, ld_err all 0.
- State machine (encoded in package enum): IDLE, LOAD, STREAM, DRAIN, DONE.
- IDLE:
  - start=1 -> LOAD next cycle.
  - On that transition: clear row counts, t counter and ld_err.
- LOAD:
  - ld_ready=1.
  - buf_en_in[ld_row] = ld_valid & ld_ready & (cnt[ld_row] < K). This is combinational so data and enable share a cycle. All other bits are 0.
  - An accepted beat increments cnt[ld_row]. cnt width is $clog2(K+1).
  - A beat to a full row or an out-of-range row: no enable, ld_err <= 1.
  - The cycle in which every cnt == K (after the update) -> STREAM next cycle.
- STREAM:
  - BEATS = K/OUT.
  - t counter runs 0 .. BEATS+ROWS-2, one step per cycle.
  - buf_en_out[r] = (t >= r) && (t - r < BEATS), driven from registered state/t. No combinational input path.
  - Final t -> DRAIN with drain counter = 0.
- DRAIN:
  - All enables 0.
  - Exit after exactly DRAIN cycles -> DONE. If DRAIN=0, go directly to DONE.
- DONE:
  - done=1 for exactly one cycle; busy=0.
  - -> IDLE.
- Latency: start accepted at cycle 0 -> LOAD at cycle 1.
  - Total from last load beat to done = 1 + (BEATS+ROWS-1) + DRAIN cycles.
- abort=1 in any non-IDLE state:
  - Next state IDLE; enables deasserted that cycle (combinational gating of buf_en_in).
  - No done; ld_err retained.
  - abort has priority over every other transition.
- start while busy: ignored. start and abort together in IDLE: abort wins (stay IDLE).
- ld_valid outside LOAD: ignored, no error.
- Reset mid-operation: immediate IDLE, outputs 0. Buffer contents are not the controller's concern.
- Arithmetic:
  - t width $clog2(BEATS+ROWS).
  - Comparisons are unsigned; t - r is evaluated only when t >= r.

Decomposition:
- Package sa_ctrl_pkg holds:
  - the state enum typedef;
  - localparam helper functions for BEATS, t width and cnt width.
- One natural sub-module, sa_row_fill_cnt: per-row saturating fill counter with full flag, instantiated ROWS times via generate.
- Skew-enable decode and FSM stay in sa_feed_ctrl.

Test Plan:
- ROWS=2,K=4,OUT=2,DRAIN=3: start, then 8 beats alternating row 0/1 -> buf_en_in one-hot each beat. STREAM buf_en_out = 01, 11, 10, then 00 for 3 cycles. done pulses on the cycle after the third drain cycle. busy is low at done.
- Fifth beat to row 0 while row 1 has 3 -> buf_en_in stays 00, ld_err=1, still in LOAD. One beat to row 1 -> STREAM starts. ld_err is cleared by the next start.
- abort asserted at STREAM t=1 -> next cycle IDLE, buf_en_out=00, no done pulse, busy=0.
- rst_n low for 1 cycle during DRAIN (asynchronous, mid-clock) -> all outputs 0 immediately. A new start performs a full correct operation.
- start pulsed during LOAD and ld_valid during STREAM -> both ignored; sequence and timing identical to the first scenario.
- ROWS=4,K=2,OUT=1,DRAIN=0 -> STREAM spans 5 cycles. buf_en_out = 0001, 0011, 0110, 1100, 1000. done on the next cycle.
